pid_servo_pwm: RTL and testbench

//   Actuator-side end of the PID loop: consumes the signed pid_out word (pulse width in us) of pid_top
//   and drives a fixed-period servo PWM pulse train. Duty is clamped to a safe window and

---
 rtl/pid_servo_pwm.sv | 141 ++++++++++++++
 tb/tb_pid_servo_pwm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pid_servo_pwm.sv
// Servo PWM generator: turns the signed PID output (pulse width in us) into a fixed-period
// pulse train, clamping the width and latching it only at frame start.
module pid_servo_pwm #(
  parameter int CLK_VAL_MHZ = 50,
  parameter int VAL_LENGTH  = 32,
  parameter int PERIOD_US   = 20000,
  parameter int MIN_US      = 500,
  parameter int MAX_US      = 2500
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         enable,
  input  logic signed [VAL_LENGTH-1:0] pid_out,
  output logic                         pwm_out,
  output logic                         frame_tick,
  output logic [15:0]                  duty_us,
  output logic                         busy
);

  localparam int PW = (CLK_VAL_MHZ > 1) ? $clog2(CLK_VAL_MHZ) : 1;
  localparam int UW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_VAL_MHZ - 1);
  localparam logic [UW-1:0] US_LAST    = UW'(PERIOD_US - 1);

  localparam logic signed [VAL_LENGTH-1:0] MIN_V = VAL_LENGTH'(MIN_US);
  localparam logic signed [VAL_LENGTH-1:0] MAX_V = VAL_LENGTH'(MAX_US);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [UW-1:0] us_q, us_d;
  logic [15:0]   duty_q, duty_d;
  logic          pwm_q, pwm_d;
  logic          tick_q, tick_d;
  logic          busy_q, busy_d;

  logic [15:0]   clamp_us;
  logic          presc_wrap;
  logic          high_done;

  // Signed compare over the full input width so large negatives land on MIN_US.
  always_comb begin
    clamp_us = 16'(MIN_US);
    if (pid_out < MIN_V)      clamp_us = 16'(MIN_US);
    else if (pid_out > MAX_V) clamp_us = 16'(MAX_US);
    else                      clamp_us = 16'(pid_out);
  end

  assign presc_wrap = (presc_q == PRESC_LAST);
  assign high_done  = presc_wrap && (32'(us_q) == (32'(duty_q) - 32'd1));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    us_d    = us_q;
    duty_d  = duty_q;
    pwm_d   = pwm_q;
    tick_d  = 1'b0;
    busy_d  = busy_q;

    if (state_q != S_IDLE) begin
      presc_d = presc_wrap ? '0 : presc_q + 1'b1;
      if (presc_wrap) us_d = (us_q == US_LAST) ? '0 : us_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        us_d    = '0;
        pwm_d   = 1'b0;
        busy_d  = 1'b0;
        if (enable) begin
          state_d = S_HIGH;
          duty_d  = clamp_us;
          pwm_d   = 1'b1;
          tick_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_HIGH: begin
        if (high_done) begin
          state_d = S_LOW;
          pwm_d   = 1'b0;
        end
      end
      S_LOW: begin
        // Last cycle of the frame: chain straight into the next one or park.
        if (presc_wrap && us_q == US_LAST) begin
          presc_d = '0;
          us_d    = '0;
          if (enable) begin
            state_d = S_HIGH;
            duty_d  = clamp_us;
            pwm_d   = 1'b1;
            tick_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
        us_d    = '0;
        pwm_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      us_q    <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      us_q    <= us_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign frame_tick = tick_q;
  assign duty_us    = duty_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pid_servo_pwm.sv
// Directed bench for pid_servo_pwm: 2 clk/us, 20 us frames, clamp window 5..15 us.
module tb_pid_servo_pwm;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic signed [31:0] pid_out;
  logic        pwm_out;
  logic        frame_tick;
  logic [15:0] duty_us;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  int cyc = 0, last_tick = 0, prev_tick = 0, tick_count = 0;
  int hi_run = 0, lo_run = 0, hi_last = 0, lo_last = 0;
  logic pwm_prev = 1'b0;

  pid_servo_pwm #(
    .CLK_VAL_MHZ(2), .VAL_LENGTH(32), .PERIOD_US(20), .MIN_US(5), .MAX_US(15)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .pid_out(pid_out),
    .pwm_out(pwm_out), .frame_tick(frame_tick), .duty_us(duty_us), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Passive observer: tick spacing and high/low run lengths, sampled on the falling edge.
  always @(negedge sys_clk) begin
    cyc = cyc + 1;
    if (frame_tick) begin
      prev_tick  = last_tick;
      last_tick  = cyc;
      tick_count = tick_count + 1;
    end
    if (pwm_out) begin
      if (!pwm_prev) begin lo_last = lo_run; lo_run = 0; end
      hi_run = hi_run + 1;
    end else begin
      if (pwm_prev) begin hi_last = hi_run; hi_run = 0; end
      lo_run = lo_run + 1;
    end
    pwm_prev = pwm_out;
  end

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_ticks(input int n, output bit ok);
    int start;
    start = tick_count;
    ok = 1'b0;
    for (int i = 0; i < 200 * n; i++) begin
      step(1);
      if (tick_count >= start + n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0; enable = 1'b1; pid_out = 32'sd10;
    step(3);
    tests++; if (pwm_out !== 1'b0) begin failed++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
    tests++; if (frame_tick !== 1'b0) begin failed++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    tests++; if (duty_us !== 16'd0) begin failed++; $display("FAIL reset_duty got=%0d exp=0", duty_us); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    bit ok;
    sys_rst_n = 1'b1;
    step(1);
    tests++; if (frame_tick !== 1'b1) begin failed++; $display("FAIL first_tick got=%b exp=1", frame_tick); end
    tests++; if (pwm_out !== 1'b1) begin failed++; $display("FAIL first_pwm got=%b exp=1", pwm_out); end
    tests++; if (duty_us !== 16'd10) begin failed++; $display("FAIL first_duty got=%0d exp=10", duty_us); end
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL first_busy got=%b exp=1", busy); end
    step(1);
    tests++; if (frame_tick !== 1'b0) begin failed++; $display("FAIL tick_width got=%b exp=0", frame_tick); end
    wait_ticks(1, ok);
    tests++; if (!ok) begin failed++; $display("FAIL basic_timeout got=0 exp=1"); end
    tests++; if (last_tick - prev_tick !== 40) begin failed++; $display("FAIL basic_period got=%0d exp=40", last_tick - prev_tick); end
    tests++; if (hi_last !== 20) begin failed++; $display("FAIL basic_high got=%0d exp=20", hi_last); end
    tests++; if (lo_last !== 20) begin failed++; $display("FAIL basic_low got=%0d exp=20", lo_last); end
  endtask

  task automatic test_clamp;
    bit ok;
    pid_out = 32'sd100;
    wait_ticks(1, ok);
    tests++; if (!ok || duty_us !== 16'd15) begin failed++; $display("FAIL clamp_hi_duty got=%0d exp=15", duty_us); end
    pid_out = -32'sd7;
    wait_ticks(1, ok);
    tests++; if (!ok || hi_last !== 30) begin failed++; $display("FAIL clamp_hi_width got=%0d exp=30", hi_last); end
    tests++; if (duty_us !== 16'd5) begin failed++; $display("FAIL clamp_neg_duty got=%0d exp=5", duty_us); end
    tests++; if (last_tick - prev_tick !== 40) begin failed++; $display("FAIL clamp_period got=%0d exp=40", last_tick - prev_tick); end
    pid_out = 32'sh8000_0000;
    wait_ticks(1, ok);
    tests++; if (!ok || hi_last !== 10) begin failed++; $display("FAIL clamp_lo_width got=%0d exp=10", hi_last); end
    tests++; if (duty_us !== 16'd5) begin failed++; $display("FAIL clamp_min_int got=%0d exp=5", duty_us); end
  endtask

  task automatic test_latch;
    bit ok;
    pid_out = 32'sd10;
    wait_ticks(1, ok);
    tests++; if (!ok || duty_us !== 16'd10) begin failed++; $display("FAIL latch_start got=%0d exp=10", duty_us); end
    step(5);
    pid_out = 32'sd12;
    step(1);
    tests++; if (duty_us !== 16'd10) begin failed++; $display("FAIL latch_hold got=%0d exp=10", duty_us); end
    wait_ticks(1, ok);
    tests++; if (!ok || hi_last !== 20) begin failed++; $display("FAIL latch_old_width got=%0d exp=20", hi_last); end
    tests++; if (duty_us !== 16'd12) begin failed++; $display("FAIL latch_new_duty got=%0d exp=12", duty_us); end
    wait_ticks(1, ok);
    tests++; if (!ok || hi_last !== 24) begin failed++; $display("FAIL latch_new_width got=%0d exp=24", hi_last); end
  endtask

  task automatic test_disable;
    int t0, fall_cyc, ticks0;
    bit stray;
    t0 = last_tick;
    fall_cyc = -1;
    step(8);
    enable = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (busy === 1'b0) begin fall_cyc = cyc; break; end
    end
    tests++; if (fall_cyc !== t0 + 40) begin failed++; $display("FAIL disable_frame_end got=%0d exp=%0d", fall_cyc, t0 + 40); end
    ticks0 = tick_count;
    stray = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (pwm_out !== 1'b0 || frame_tick !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    tests++; if (stray !== 1'b0 || tick_count !== ticks0) begin failed++; $display("FAIL idle_quiet got=%0d exp=%0d", tick_count, ticks0); end
    pid_out = 32'sd10;
    enable = 1'b1;
    step(1);
    tests++; if (frame_tick !== 1'b1 || pwm_out !== 1'b1) begin failed++; $display("FAIL restart_tick got=%b exp=1", frame_tick); end
    tests++; if (duty_us !== 16'd10) begin failed++; $display("FAIL restart_duty got=%0d exp=10", duty_us); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    step(25);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    wait_ticks(1, ok);
    tests++; if (!ok || last_tick - prev_tick !== 40) begin failed++; $display("FAIL b2b_period1 got=%0d exp=40", last_tick - prev_tick); end
    wait_ticks(1, ok);
    tests++; if (!ok || last_tick - prev_tick !== 40) begin failed++; $display("FAIL b2b_period2 got=%0d exp=40", last_tick - prev_tick); end
  endtask

  task automatic test_reset_mid_high;
    step(3);
    tests++; if (pwm_out !== 1'b1) begin failed++; $display("FAIL pre_reset_pwm got=%b exp=1", pwm_out); end
    #2 sys_rst_n = 1'b0;
    #1;
    tests++; if (pwm_out !== 1'b0) begin failed++; $display("FAIL async_pwm got=%b exp=0", pwm_out); end
    tests++; if (busy !== 1'b0 || duty_us !== 16'd0) begin failed++; $display("FAIL async_state got=%b/%0d exp=0/0", busy, duty_us); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_clamp;
    test_latch;
    test_disable;
    test_back_to_back;
    test_reset_mid_high;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
